// File: rtl/segment_scan_mux.sv
// Time-multiplexed 7-segment scan driver for NUM_FIELDS two-digit binary fields.
// Optional leading-zero blanking of the top digit: define SEGMENT_SCAN_LZB_EN.
module segment_scan_mux #(
  parameter int NUM_FIELDS = 2,
  parameter int FIELD_W    = 6,
  parameter int SCAN_DIV   = 1000,
  parameter int MAX_VAL    = 59
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_FIELDS*FIELD_W-1:0]  data_show,
  input  logic                           data_valid,
  output logic [2*NUM_FIELDS-1:0]        digit_en,
  output logic [6:0]                     segment,
  output logic                           frame_done
);
  localparam int NUM_DIGITS = 2 * NUM_FIELDS;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [FIELD_W-1:0] TEN  = FIELD_W'(10);
  localparam logic [6:0]         DASH = 7'b1000000;

  typedef enum logic {PH_ON, PH_BLANK} phase_t;

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'd0:    dec = 7'b0111111;
      4'd1:    dec = 7'b0000110;
      4'd2:    dec = 7'b1011011;
      4'd3:    dec = 7'b1001111;
      4'd4:    dec = 7'b1100110;
      4'd5:    dec = 7'b1101101;
      4'd6:    dec = 7'b1111101;
      4'd7:    dec = 7'b0000111;
      4'd8:    dec = 7'b1111111;
      4'd9:    dec = 7'b1101111;
      default: dec = DASH;
    endcase
  endfunction

  logic [CW-1:0]                  cnt;
  phase_t                         phase;
  logic [IW-1:0]                  idx;
  logic [NUM_FIELDS*FIELD_W-1:0]  pending, shadow;
  logic [NUM_DIGITS-1:0][6:0]     dig_seg;
  logic                           tick, wrap;

  assign tick = (cnt == CW'(SCAN_DIV - 1));
  assign wrap = tick && (phase == PH_BLANK) && (idx == IW'(NUM_DIGITS - 1));

  // Per-field split and decode; dig_seg holds the pattern for every digit slot.
  for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_field
    logic [FIELD_W-1:0] v, tens;
    logic [3:0]         ones;
    logic               over;
    logic [6:0]         tens_seg;
`ifdef SEGMENT_SCAN_LZB_EN
    localparam bit LZB = (k == NUM_FIELDS - 1);
`else
    localparam bit LZB = 1'b0;
`endif
    assign v        = shadow[k*FIELD_W +: FIELD_W];
    assign over     = 32'(v) > MAX_VAL;
    assign tens     = v / TEN;
    assign ones     = 4'(v % TEN);
    assign tens_seg = (over || 32'(tens) > 9) ? DASH : dec(4'(tens));
    assign dig_seg[2*k]   = over ? DASH : dec(ones);
    assign dig_seg[2*k+1] = (LZB && !over && tens == '0) ? 7'd0 : tens_seg;
  end

  // Outputs are registered from the pre-edge state, so they lag the FSM by a cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      phase      <= PH_ON;
      idx        <= '0;
      pending    <= '0;
      shadow     <= '0;
      digit_en   <= '0;
      segment    <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + CW'(1);
      frame_done <= wrap;
      if (data_valid) pending <= data_show;
      // shadow samples pending before this edge's capture, so a colliding strobe waits a frame
      if (wrap) shadow <= pending;
      if (tick) begin
        if (phase == PH_ON) begin
          phase <= PH_BLANK;
        end else begin
          phase <= PH_ON;
          idx   <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
        end
      end
      if (phase == PH_ON) begin
        digit_en <= NUM_DIGITS'(1) << idx;
        segment  <= dig_seg[idx];
      end else begin
        digit_en <= '0;
        segment  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_segment_scan_mux.sv
// Directed bench for segment_scan_mux: SCAN_DIV=4, two fields, 32-cycle frames.
module tb_segment_scan_mux;
  localparam int NF = 2;
  localparam int FW = 6;
  localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011,
                         S3 = 7'b1001111, S4 = 7'b1100110, S5 = 7'b1101101,
                         S7 = 7'b0000111, S9 = 7'b1101111, DASH = 7'b1000000;
`ifdef SEGMENT_SCAN_LZB_EN
  localparam logic [6:0] TOP0 = 7'b0000000;
`else
  localparam logic [6:0] TOP0 = S0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic [NF*FW-1:0]  data_show;
  logic              data_valid;
  logic [2*NF-1:0]   digit_en;
  logic [6:0]        segment;
  logic              frame_done;

  int n_chk = 0;
  int n_pass = 0;

  segment_scan_mux #(.NUM_FIELDS(NF), .FIELD_W(FW), .SCAN_DIV(4), .MAX_VAL(59)) dut (
    .clock(clock), .reset(reset), .data_show(data_show), .data_valid(data_valid),
    .digit_en(digit_en), .segment(segment), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Checks one full frame starting at the first edge after a wrap (or reset release).
  // Optionally strobes data_valid so that it is captured on the edge before sample pcyc.
  task automatic scan_frame(input string name, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3,
                            input bit do_pulse, input int pcyc, input logic [NF*FW-1:0] pdata);
    logic [6:0] segs [4];
    logic [3:0] exp_en;
    logic [6:0] exp_seg;
    segs[0] = e0; segs[1] = e1; segs[2] = e2; segs[3] = e3;
    for (int c = 0; c < 32; c++) begin
      if (do_pulse && c == pcyc) begin
        data_show  = pdata;
        data_valid = 1'b1;
      end
      @(negedge clock);
      data_valid = 1'b0;
      exp_en  = ((c / 4) % 2 == 0) ? 4'(1 << (c / 8)) : 4'd0;
      exp_seg = ((c / 4) % 2 == 0) ? segs[c / 8] : 7'd0;
      chk($sformatf("%s en c%0d", name, c), 32'(digit_en), 32'(exp_en));
      chk($sformatf("%s seg c%0d", name, c), 32'(segment), 32'(exp_seg));
      chk($sformatf("%s done c%0d", name, c), 32'(frame_done), (c == 31) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    data_valid = 1'b0;
    data_show  = '0;
    repeat (2) @(negedge clock);
    chk("rst en", 32'(digit_en), 32'd0);
    chk("rst seg", 32'(segment), 32'd0);
    chk("rst done", 32'(frame_done), 32'd0);
    reset = 1'b0;

    scan_frame("boot", S0, S0, S0, S0, 1'b1, 10, {6'd12, 6'd34});
    scan_frame("dec", S4, S3, S2, S1, 1'b1, 31, {6'd12, 6'd59});
    scan_frame("coll", S4, S3, S2, S1, 1'b0, 0, '0);
    scan_frame("f59", S9, S5, S2, S1, 1'b1, 5, {6'd12, 6'd60});
    scan_frame("oor", DASH, DASH, S2, S1, 1'b1, 3, {6'd5, 6'd7});
    scan_frame("lzb", S7, S0, S5, TOP0, 1'b0, 0, '0);

    for (int c = 0; c < 18; c++) @(negedge clock);
    chk("mid en", 32'(digit_en), 32'b0100);
    chk("mid seg", 32'(segment), 32'(S5));
    #2 reset = 1'b1;
    #1;
    chk("async en", 32'(digit_en), 32'd0);
    chk("async seg", 32'(segment), 32'd0);
    @(posedge clock);
    @(negedge clock);
    chk("held done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    scan_frame("rst2", S0, S0, S0, S0, 1'b0, 0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/segment_scan_mux.md
Name: segment_scan_mux

Overview:
- Parametrised, time-multiplexed 7-segment scan driver for the clock display. Successor to the fixed 4-digit, 8-slot scan with its hard-wired 2-field hh:mm split.
- Takes NUM_FIELDS packed binary fields, e.g. hh:mm or hh:mm:ss. Splits each field into tens/ones, decodes each digit to segments, and scans the digits with a blanking slot between them to suppress ghosting.
- Input data is double-buffered and applied only at frame boundaries, so the display never tears.

Parameters:
- NUM_FIELDS, 2: number of 2-digit fields; NUM_DIGITS = 2*NUM_FIELDS (localparam).
- FIELD_W, 6: bit width of each binary field.
- SCAN_DIV, 1000: clock cycles per scan slot; legal minimum 2.
- MAX_VAL, 59: largest displayable field value; larger values show a dash pair.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- data_show  in  NUM_FIELDS*FIELD_W  packed fields; field k = data_show[k*FIELD_W +: FIELD_W]; field 0 is the rightmost pair.
- data_valid  in  1  one-cycle strobe; captures data_show into the pending register.
- digit_en  out  NUM_DIGITS  one-hot, active-high digit select; bit 0 = rightmost digit.
- segment  out  7  active-high segments, order {g,f,e,d,c,b,a}.
- frame_done  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset, asynchronous while reset=1:
  - prescaler=0; state=ON, digit index=0.
  - pending=0, shadow=0.
  - digit_en=0, segment=0, frame_done=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - tick is asserted in the cycle where the count equals SCAN_DIV-1.
- Scan FSM: two phases (ON, BLANK) plus a digit index d in 0..NUM_DIGITS-1. Transitions on tick only:
  - ON(d) -> BLANK(d).
  - BLANK(d) -> ON(d+1) for d < NUM_DIGITS-1.
  - BLANK(NUM_DIGITS-1) -> ON(0). This is the frame wrap.
- Frame length: 2*NUM_DIGITS*SCAN_DIV cycles.
- Frame wrap, in the same clock edge:
  - shadow <= pending.
  - frame_done registered high for exactly 1 cycle.
- data_valid:
  - pending <= data_show on any cycle with data_valid=1.
  - If data_valid coincides with the frame-wrap edge, shadow takes the OLD pending. The new value appears in the next frame.
- Digit mapping: digit 2k shows ones(shadow field k); digit 2k+1 shows tens(shadow field k).
  - tens = v/10 and ones = v%10, computed on the FIELD_W-bit unsigned value.
  - If v > MAX_VAL, both digits of that field show a dash (segment=7'b1000000).
- Segment decode, 0..9 (gfedcba): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
- Outputs are registered from the FSM state, so they change 1 cycle after the state transition:
  - ON phase: digit_en = 1<<d; segment = decoded value.
  - BLANK phase: digit_en=0, segment=0.
- After reset release: the first edge drives digit_en=...0001 with the digit-0 pattern of shadow=0 (i.e. "0").
- Reset asserted mid-frame: outputs clear immediately; the scan restarts at ON(0) with a full slot length.

Optional Feature:
- Macro: SEGMENT_SCAN_LZB_EN (leading-zero blanking).
- Defined: if the tens digit of the highest field (digit NUM_DIGITS-1) is 0 and that field is ≤ MAX_VAL, segment=0 during its ON slot. digit_en still asserts normally, so slot timing is unchanged.
- Not defined: that digit shows "0" like any other digit. No other logic differs.

Test Plan:
- Reset timing (SCAN_DIV=4, NUM_FIELDS=2): release reset, hold data at 0 -> digit_en sequence is 0001,0000,0010,0000,0100,0000,1000,0000, each slot 4 cycles. segment=0111111 in each ON slot. frame_done pulses every 32 cycles.
- Decode: data_valid with field1=12, field0=34 -> from the next frame, digit0=1100110 (4), digit1=1001111 (3), digit2=1011011 (2), digit3=0000110 (1). Mid-frame, the old digits persist until the wrap.
- Wrap collision: pulse data_valid on the frame-wrap cycle with field0=59 -> the current frame shows the previous value; the following frame shows 9 (1101111) and 5 (1101101).
- Out of range: field0=60 -> digits 0 and 1 both show 1000000; field1 is unaffected.
- Reset mid-slot: assert reset during ON(2) -> same cycle, digit_en=0 and segment=0. After release, the scan restarts at digit 0 with a full 4-cycle slot.
- Leading-zero blanking: field1=5, with and without SEGMENT_SCAN_LZB_EN -> digit3 segment=0 vs 0111111; digit_en timing is identical in both builds.
